// File: rtl/ibus_pkg.sv
// Shared constants and types for the instruction-bus arbiter.
package ibus_pkg;

  localparam int IBUS_ADDR_W = 30;
  localparam int IBUS_DATA_W = 32;

  // Master indices; also the encoding of a grant.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Arbitration modes.
  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  localparam int         STARVE_CNT_W = 8;
  localparam logic [7:0] STARVE_SAT   = 8'hFF;

  // Lock state of the slave port while the granted read is stalled.
  typedef enum logic {
    LOCK_OPEN = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_t;

  // Saturating increment for the starvation counter.
  function automatic logic [STARVE_CNT_W-1:0] sat_inc(input logic [STARVE_CNT_W-1:0] v);
    return (v == STARVE_SAT) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ibus_arb_grant.sv
// Grant selection for two read masters, plus the round-robin pointer and
// the M1 starvation counter used by fixed-priority mode.
module ibus_arb_grant
  import ibus_pkg::*;
#(
  parameter int PRIO_MODE  = PRIO_RR,
  parameter int STARVE_MAX = 8
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_M0_Read,
  input  logic i_M1_Read,
  input  logic i_Lock,
  input  logic i_Owner,
  input  logic i_IBus_WaitReq,
  output logic o_Gnt,
  output logic o_GntRead,
  output logic o_Accept
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

  logic                    r_LastGnt;
  logic [STARVE_CNT_W-1:0] r_StarveCnt;
  logic                    w_StarveHit;
  logic                    w_M1_Accepted;

  assign w_StarveHit = (r_StarveCnt >= STARVE_LIM);

  // Pick the master that owns the slave port this cycle.
  always_comb begin
    o_Gnt = r_LastGnt;
    if (i_Lock) begin
      o_Gnt = i_Owner;
    end else if (i_M0_Read && !i_M1_Read) begin
      o_Gnt = M0;
    end else if (!i_M0_Read && i_M1_Read) begin
      o_Gnt = M1;
    end else if (i_M0_Read && i_M1_Read) begin
      if (PRIO_MODE == PRIO_FIXED) begin
        o_Gnt = w_StarveHit ? M1 : M0;
      end else begin
        o_Gnt = ~r_LastGnt;
      end
    end
  end

  assign o_GntRead     = (o_Gnt == M1) ? i_M1_Read : i_M0_Read;
  assign o_Accept      = o_GntRead && !i_IBus_WaitReq;
  assign w_M1_Accepted = o_Accept && (o_Gnt == M1);

  // Round-robin pointer follows the last accepted master; reset favours M0.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_LastGnt <= M1;
    end else if (o_Accept) begin
      r_LastGnt <= o_Gnt;
    end
  end

  // Count consecutive cycles M1 waits; only meaningful in fixed-priority mode.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_StarveCnt <= '0;
    end else if (PRIO_MODE != PRIO_FIXED) begin
      r_StarveCnt <= '0;
    end else if (!i_M1_Read || w_M1_Accepted) begin
      r_StarveCnt <= '0;
    end else begin
      r_StarveCnt <= sat_inc(r_StarveCnt);
    end
  end

endmodule

// File: rtl/ibus_arbiter.sv
// Two-master arbiter in front of the read-only instruction-bus slave port.
// Request path is combinational; responses return one cycle after acceptance.
//
// Lock state | meaning
// -----------+-------------------------------------------------------------
// LOCK_OPEN  | no stalled read outstanding; grant decided fresh each cycle
// LOCK_HELD  | granted read was stalled; grant pinned to r_Owner until it
//            | is accepted or the owner drops its request
module ibus_arbiter
  import ibus_pkg::*;
#(
  parameter int ADDR_W     = IBUS_ADDR_W,
  parameter int DATA_W     = IBUS_DATA_W,
  parameter int PRIO_MODE  = PRIO_RR,
  parameter int STARVE_MAX = 8
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [ADDR_W-1:0] i_M0_Address,
  input  logic              i_M0_Read,
  output logic              o_M0_WaitReq,
  output logic [DATA_W-1:0] o_M0_ReadData,
  output logic              o_M0_ReadValid,
  input  logic [ADDR_W-1:0] i_M1_Address,
  input  logic              i_M1_Read,
  output logic              o_M1_WaitReq,
  output logic [DATA_W-1:0] o_M1_ReadData,
  output logic              o_M1_ReadValid,
  output logic [ADDR_W-1:0] o_IBus_Address,
  output logic              o_IBus_Read,
  input  logic [DATA_W-1:0] i_IBus_ReadData,
  input  logic              i_IBus_WaitReq
);

  lock_state_t r_Lock;
  lock_state_t w_LockNext;
  logic        r_Owner;
  logic        w_OwnerNext;
  logic        r_RspValid;
  logic        r_RspOwner;

  logic        w_Gnt;
  logic        w_GntRead;
  logic        w_Accept;

  ibus_arb_grant #(
    .PRIO_MODE  (PRIO_MODE),
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .i_Clk          (i_Clk),
    .i_Rst          (i_Rst),
    .i_M0_Read      (i_M0_Read),
    .i_M1_Read      (i_M1_Read),
    .i_Lock         (r_Lock == LOCK_HELD),
    .i_Owner        (r_Owner),
    .i_IBus_WaitReq (i_IBus_WaitReq),
    .o_Gnt          (w_Gnt),
    .o_GntRead      (w_GntRead),
    .o_Accept       (w_Accept)
  );

  // Lock state register.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Lock  <= LOCK_OPEN;
      r_Owner <= M0;
    end else begin
      r_Lock  <= w_LockNext;
      r_Owner <= w_OwnerNext;
    end
  end

  // Hold the lock only while the granted read is present and stalled; a
  // dropped request or an acceptance both reopen arbitration.
  always_comb begin
    w_LockNext  = LOCK_OPEN;
    w_OwnerNext = r_Owner;
    if (w_GntRead && i_IBus_WaitReq) begin
      w_LockNext  = LOCK_HELD;
      w_OwnerNext = w_Gnt;
    end
  end

  // Remember who owns the response arriving next cycle.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_RspValid <= 1'b0;
      r_RspOwner <= M0;
    end else begin
      r_RspValid <= w_Accept;
      if (w_Accept) begin
        r_RspOwner <= w_Gnt;
      end
    end
  end

  assign o_IBus_Address = (w_Gnt == M1) ? i_M1_Address : i_M0_Address;
  assign o_IBus_Read    = w_GntRead;

  assign o_M0_WaitReq   = (w_Gnt == M0) ? i_IBus_WaitReq : 1'b1;
  assign o_M1_WaitReq   = (w_Gnt == M1) ? i_IBus_WaitReq : 1'b1;

  assign o_M0_ReadData  = i_IBus_ReadData;
  assign o_M1_ReadData  = i_IBus_ReadData;
  assign o_M0_ReadValid = r_RspValid && (r_RspOwner == M0);
  assign o_M1_ReadValid = r_RspValid && (r_RspOwner == M1);

endmodule

// File: tb/tb_ibus_arbiter.sv
// Directed bench: one round-robin and one fixed-priority arbiter share stimulus.
module tb_ibus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] m0_addr, m1_addr;
  logic        m0_rd, m1_rd;
  logic [31:0] rdata;
  logic        swait;

  logic        rr_m0_wait, rr_m1_wait, rr_m0_rv, rr_m1_rv, rr_ibus_read;
  logic [31:0] rr_m0_rdata, rr_m1_rdata;
  logic [29:0] rr_ibus_addr;
  logic        fp_m0_wait, fp_m1_wait, fp_m0_rv, fp_m1_rv, fp_ibus_read;
  logic [31:0] fp_m0_rdata, fp_m1_rdata;
  logic [29:0] fp_ibus_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ibus_arbiter #(.PRIO_MODE(0), .STARVE_MAX(8)) u_rr (
    .i_Clk(clk), .i_Rst(rst),
    .i_M0_Address(m0_addr), .i_M0_Read(m0_rd), .o_M0_WaitReq(rr_m0_wait),
    .o_M0_ReadData(rr_m0_rdata), .o_M0_ReadValid(rr_m0_rv),
    .i_M1_Address(m1_addr), .i_M1_Read(m1_rd), .o_M1_WaitReq(rr_m1_wait),
    .o_M1_ReadData(rr_m1_rdata), .o_M1_ReadValid(rr_m1_rv),
    .o_IBus_Address(rr_ibus_addr), .o_IBus_Read(rr_ibus_read),
    .i_IBus_ReadData(rdata), .i_IBus_WaitReq(swait)
  );

  ibus_arbiter #(.PRIO_MODE(1), .STARVE_MAX(4)) u_fp (
    .i_Clk(clk), .i_Rst(rst),
    .i_M0_Address(m0_addr), .i_M0_Read(m0_rd), .o_M0_WaitReq(fp_m0_wait),
    .o_M0_ReadData(fp_m0_rdata), .o_M0_ReadValid(fp_m0_rv),
    .i_M1_Address(m1_addr), .i_M1_Read(m1_rd), .o_M1_WaitReq(fp_m1_wait),
    .o_M1_ReadData(fp_m1_rdata), .o_M1_ReadValid(fp_m1_rv),
    .o_IBus_Address(fp_ibus_addr), .o_IBus_Read(fp_ibus_read),
    .i_IBus_ReadData(rdata), .i_IBus_WaitReq(swait)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs then change, checks follow #1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; m0_addr = '0; m1_addr = '0; m0_rd = 1'b0; m1_rd = 1'b0;
    rdata = '0; swait = 1'b0;
    tick(); tick();
    #1;
    chk("rst_rr_ibus_read", rr_ibus_read, 0);
    chk("rst_rr_m0_rv", rr_m0_rv, 0);
    chk("rst_rr_m1_rv", rr_m1_rv, 0);
    chk("rst_fp_ibus_read", fp_ibus_read, 0);

    // M0-only stream 0x10..0x12
    tick(); rst = 1'b0; m0_rd = 1'b1; m0_addr = 30'h10; #1;
    chk("s1_addr0", rr_ibus_addr, 32'h10);
    chk("s1_read0", rr_ibus_read, 1);
    chk("s1_m0_wait", rr_m0_wait, 0);
    chk("s1_m0_rv0", rr_m0_rv, 0);
    tick(); m0_addr = 30'h11; rdata = 32'hA000_0010; #1;
    chk("s1_addr1", rr_ibus_addr, 32'h11);
    chk("s1_m0_rv1", rr_m0_rv, 1);
    chk("s1_m0_data1", rr_m0_rdata, 32'hA000_0010);
    chk("s1_m1_rv1", rr_m1_rv, 0);
    tick(); m0_addr = 30'h12; rdata = 32'hA000_0011; #1;
    chk("s1_addr2", rr_ibus_addr, 32'h12);
    chk("s1_m0_rv2", rr_m0_rv, 1);
    chk("s1_m0_data2", rr_m0_rdata, 32'hA000_0011);
    tick(); m0_rd = 1'b0; rdata = 32'hA000_0012; #1;
    chk("s1_m0_rv3", rr_m0_rv, 1);
    chk("s1_m0_data3", rr_m0_rdata, 32'hA000_0012);
    chk("s1_read_idle", rr_ibus_read, 0);
    chk("s1_m1_rv3", rr_m1_rv, 0);
    tick(); rdata = '0; #1;
    chk("s1_m0_rv4", rr_m0_rv, 0);

    // M1 read returning 0xDEADBEEF
    tick(); m1_rd = 1'b1; m1_addr = 30'h55; #1;
    chk("s6_addr", rr_ibus_addr, 32'h55);
    chk("s6_m1_wait", rr_m1_wait, 0);
    chk("s6_m0_wait", rr_m0_wait, 1);
    tick(); m1_rd = 1'b0; rdata = 32'hDEAD_BEEF; #1;
    chk("s6_m1_rv", rr_m1_rv, 1);
    chk("s6_m1_data", rr_m1_rdata, 32'hDEAD_BEEF);
    chk("s6_m0_rv", rr_m0_rv, 0);
    chk("s6_fp_m1_rv", fp_m1_rv, 1);

    // Round-robin tie; last grant was M1 so M0 goes first
    tick(); m0_rd = 1'b1; m0_addr = 30'h100; m1_rd = 1'b1; m1_addr = 30'h200; rdata = '0; #1;
    chk("rr_addr0", rr_ibus_addr, 32'h100);
    chk("rr_m0_wait0", rr_m0_wait, 0);
    chk("rr_m1_wait0", rr_m1_wait, 1);
    tick(); rdata = 32'h1111_0000; #1;
    chk("rr_addr1", rr_ibus_addr, 32'h200);
    chk("rr_m0_rv1", rr_m0_rv, 1);
    chk("rr_m1_rv1", rr_m1_rv, 0);
    chk("rr_m0_data1", rr_m0_rdata, 32'h1111_0000);
    tick(); rdata = 32'h2222_0000; #1;
    chk("rr_addr2", rr_ibus_addr, 32'h100);
    chk("rr_m1_rv2", rr_m1_rv, 1);
    chk("rr_m0_rv2", rr_m0_rv, 0);
    chk("rr_m1_data2", rr_m1_rdata, 32'h2222_0000);
    tick(); rdata = 32'h3333_0000; #1;
    chk("rr_addr3", rr_ibus_addr, 32'h200);
    chk("rr_m0_rv3", rr_m0_rv, 1);
    tick(); m0_rd = 1'b0; m1_rd = 1'b0; rdata = 32'h4444_0000; #1;
    chk("rr_m1_rv4", rr_m1_rv, 1);
    chk("rr_m0_rv4", rr_m0_rv, 0);

    // Stall lock: M1 stalled 3 cycles while M0 waits behind it
    tick(); m1_rd = 1'b1; m1_addr = 30'h200; swait = 1'b1; rdata = '0; #1;
    chk("lk_addr0", rr_ibus_addr, 32'h200);
    chk("lk_m1_wait0", rr_m1_wait, 1);
    chk("lk_m1_rv0", rr_m1_rv, 0);
    tick(); m0_rd = 1'b1; m0_addr = 30'h100; #1;
    chk("lk_addr1", rr_ibus_addr, 32'h200);
    chk("lk_m0_wait1", rr_m0_wait, 1);
    chk("lk_fp_addr1", fp_ibus_addr, 32'h200);
    chk("lk_fp_m0_wait1", fp_m0_wait, 1);
    tick(); #1;
    chk("lk_addr2", rr_ibus_addr, 32'h200);
    chk("lk_m0_wait2", rr_m0_wait, 1);
    tick(); swait = 1'b0; #1;
    chk("lk_addr3", rr_ibus_addr, 32'h200);
    chk("lk_m0_wait3", rr_m0_wait, 1);
    chk("lk_m1_wait3", rr_m1_wait, 0);
    tick(); m1_rd = 1'b0; rdata = 32'h5A5A_5A5A; #1;
    chk("lk_addr4", rr_ibus_addr, 32'h100);
    chk("lk_m0_wait4", rr_m0_wait, 0);
    chk("lk_m1_rv4", rr_m1_rv, 1);
    chk("lk_m1_data4", rr_m1_rdata, 32'h5A5A_5A5A);
    tick(); m0_rd = 1'b0; #1;
    chk("lk_m0_rv5", rr_m0_rv, 1);
    chk("lk_m1_rv5", rr_m1_rv, 0);

    // Fixed priority with STARVE_MAX=4: M0 x4 then M1 once, repeating
    for (int i = 0; i < 10; i++) begin
      tick(); m0_rd = 1'b1; m1_rd = 1'b1; #1;
      chk("sv_addr", fp_ibus_addr, ((i % 5) == 4) ? 32'h200 : 32'h100);
      if (i > 0) chk("sv_m1_rv", fp_m1_rv, (((i - 1) % 5) == 4) ? 32'd1 : 32'd0);
    end
    tick(); m0_rd = 1'b0; m1_rd = 1'b0; rdata = 32'h6666_0000; #1;
    chk("sv_m1_rv_last", fp_m1_rv, 1);
    chk("sv_m1_data_last", fp_m1_rdata, 32'h6666_0000);

    // Reset in the cycle after an M0 acceptance, with a stalled tie pending
    tick(); m0_rd = 1'b1; m0_addr = 30'h300; #1;
    chk("rs_addr0", rr_ibus_addr, 32'h300);
    tick(); rst = 1'b1; m0_addr = 30'h301; m1_rd = 1'b1; swait = 1'b1; rdata = 32'h7777_7777; #1;
    chk("rs_m0_rv1", rr_m0_rv, 1);
    chk("rs_m0_data1", rr_m0_rdata, 32'h7777_7777);
    chk("rs_addr1", rr_ibus_addr, 32'h200);
    tick(); rst = 1'b0; swait = 1'b0; #1;
    chk("rs_m0_rv2", rr_m0_rv, 0);
    chk("rs_m1_rv2", rr_m1_rv, 0);
    chk("rs_addr2", rr_ibus_addr, 32'h301);
    chk("rs_fp_addr2", fp_ibus_addr, 32'h301);
    chk("rs_fp_m0_rv2", fp_m0_rv, 0);
    tick(); rdata = 32'h8888_0000; #1;
    chk("rs_addr3", rr_ibus_addr, 32'h200);
    chk("rs_m0_rv3", rr_m0_rv, 1);
    chk("rs_fp_m0_data3", fp_m0_rdata, 32'h8888_0000);
    tick(); #1;
    chk("rs_fp_addr4", fp_ibus_addr, 32'h301);
    tick(); #1;
    chk("rs_fp_addr5", fp_ibus_addr, 32'h301);
    tick(); #1;
    chk("rs_fp_addr6", fp_ibus_addr, 32'h200);
    chk("rs_fp_m1_wait6", fp_m1_wait, 0);
    tick(); m0_rd = 1'b0; m1_rd = 1'b0; #1;
    chk("rs_fp_m1_rv7", fp_m1_rv, 1);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
